// File: rtl/decode_pipe.sv
// MIPS instruction decode stage with valid/ready flow control on both sides.
// Decode is combinational on the incoming word. The decoded bundle is captured
// into either the main register, which drives the outputs, or a one-deep skid
// register that absorbs the word accepted in the same cycle downstream stalls.
//
// Handshake: a transfer happens on a rising edge where valid && ready are both 1.
// The sender holds valid and data steady until that transfer takes place.
// in_ready is a registered term (!skid_valid) and does not depend on out_ready.
// While out_valid && !out_ready, every output stays unchanged.
module decode_pipe #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [31:0]           instruction,
  input  logic [ADDR_WIDTH-1:0] pc_in,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [5:0]            op,
  output logic [4:0]            rs,
  output logic [4:0]            rt,
  output logic [4:0]            rd,
  output logic [4:0]            sham,
  output logic [5:0]            funct,
  output logic [15:0]           imm16,
  output logic [25:0]           imm26,
  output logic [1:0]            format,
  output logic [DATA_WIDTH-1:0] imm_ext,
  output logic [ADDR_WIDTH-1:0] jump_target,
  output logic [ADDR_WIDTH-1:0] pc_out
);

  // The instruction fields are kept as the raw word. Only the derived values
  // are stored as separate fields.
  typedef struct packed {
    logic [31:0]           instr;
    logic [1:0]            fmt;
    logic [DATA_WIDTH-1:0] imm_ext;
    logic [ADDR_WIDTH-1:0] jt;
    logic [ADDR_WIDTH-1:0] pc;
  } bundle_t;

  localparam logic [1:0] FMT_R = 2'b00;
  localparam logic [1:0] FMT_I = 2'b01;
  localparam logic [1:0] FMT_J = 2'b10;

  // Bits below the jump region (28 bits) come from imm26; bits above come from pc+4.
  localparam logic [ADDR_WIDTH-1:0] JT_LOW_MASK = ADDR_WIDTH'(28'hFFF_FFFF);

  bundle_t               dec;
  logic [ADDR_WIDTH-1:0] pc_plus4;
  logic [5:0]            dec_op;
  logic [15:0]           dec_imm;

  bundle_t main_q, main_d;
  bundle_t skid_q, skid_d;
  logic    main_valid_q, main_valid_d;
  logic    skid_valid_q, skid_valid_d;

  logic accept;
  logic out_evt;
  logic main_load;

  // Combinational decode of the incoming word and pc.
  always_comb begin
    dec      = '0;
    dec_op   = instruction[31:26];
    dec_imm  = instruction[15:0];
    pc_plus4 = pc_in + ADDR_WIDTH'(32'd4);

    dec.instr = instruction;
    dec.pc    = pc_in;
    dec.jt    = (pc_plus4 & ~JT_LOW_MASK) | ADDR_WIDTH'({instruction[25:0], 2'b00});

    if (dec_op == 6'h00) begin
      dec.fmt = FMT_R;
    end else if (dec_op == 6'h02 || dec_op == 6'h03) begin
      dec.fmt = FMT_J;
    end else begin
      dec.fmt = FMT_I;
    end

    case (dec_op)
      6'h0C, 6'h0D, 6'h0E: dec.imm_ext = DATA_WIDTH'(dec_imm);
      6'h0F:               dec.imm_ext = DATA_WIDTH'({dec_imm, 16'h0000});
      default:             dec.imm_ext = {{(DATA_WIDTH-16){dec_imm[15]}}, dec_imm};
    endcase
  end

  assign in_ready  = !skid_valid_q;
  assign out_valid = main_valid_q;
  assign accept    = in_valid && in_ready;
  assign out_evt   = main_valid_q && out_ready;
  assign main_load = !main_valid_q || out_evt;

  // Next-state logic for the main and skid registers. Flush takes priority.
  always_comb begin
    main_d       = main_q;
    skid_d       = skid_q;
    main_valid_d = main_valid_q;
    skid_valid_d = skid_valid_q;

    if (flush) begin
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else if (main_load) begin
      if (skid_valid_q) begin
        // in_ready is low while the skid is full, so no input arrives here.
        main_d       = skid_q;
        main_valid_d = 1'b1;
        skid_valid_d = 1'b0;
      end else if (accept) begin
        main_d       = dec;
        main_valid_d = 1'b1;
      end else begin
        main_valid_d = 1'b0;
      end
    end else if (accept) begin
      skid_d       = dec;
      skid_valid_d = 1'b1;
    end
  end

  // State registers. Reset clears the valid bits and the data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_q       <= '0;
      skid_q       <= '0;
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
    end else begin
      main_q       <= main_d;
      skid_q       <= skid_d;
      main_valid_q <= main_valid_d;
      skid_valid_q <= skid_valid_d;
    end
  end

  assign op          = main_q.instr[31:26];
  assign rs          = main_q.instr[25:21];
  assign rt          = main_q.instr[20:16];
  assign rd          = main_q.instr[15:11];
  assign sham        = main_q.instr[10:6];
  assign funct       = main_q.instr[5:0];
  assign imm16       = main_q.instr[15:0];
  assign imm26       = main_q.instr[25:0];
  assign format      = main_q.fmt;
  assign imm_ext     = main_q.imm_ext;
  assign jump_target = main_q.jt;
  assign pc_out      = main_q.pc;

endmodule

// File: tb/tb_decode_pipe.sv
// Bench for decode_pipe: directed cases followed by randomized traffic.
// The reference is a FIFO of accepted {instruction, pc} pairs. Occupancy
// determines out_valid and in_ready, and the head entry is decoded from the
// architectural rules.
module tb_decode_pipe;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] instruction = '0;
  logic [31:0] pc_in = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [5:0]  op;
  logic [4:0]  rs, rt, rd, sham;
  logic [5:0]  funct;
  logic [15:0] imm16;
  logic [25:0] imm26;
  logic [1:0]  format;
  logic [31:0] imm_ext;
  logic [31:0] jump_target;
  logic [31:0] pc_out;

  decode_pipe #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .instruction(instruction), .pc_in(pc_in),
    .out_valid(out_valid), .out_ready(out_ready),
    .op(op), .rs(rs), .rt(rt), .rd(rd), .sham(sham), .funct(funct),
    .imm16(imm16), .imm26(imm26), .format(format),
    .imm_ext(imm_ext), .jump_target(jump_target), .pc_out(pc_out)
  );

  // ---------------- scoreboard ----------------
  logic [63:0] exp_q[$];   // {instruction, pc} in acceptance order
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference decode, derived from the architectural rules.
  task automatic check_bundle(input logic [63:0] e);
    logic [31:0] ins, pc, ref_ext, ref_jt;
    logic [15:0] imm;
    logic [5:0]  o;
    logic [1:0]  ref_fmt;
    ins = e[63:32];
    pc  = e[31:0];
    o   = ins[31:26];
    imm = ins[15:0];
    if (o == 0) ref_fmt = 2'd0;
    else if (o == 2 || o == 3) ref_fmt = 2'd2;
    else ref_fmt = 2'd1;
    if (o >= 6'h0C && o <= 6'h0E) ref_ext = 32'(imm);
    else if (o == 6'h0F) ref_ext = 32'(imm) * 32'd65536;
    else ref_ext = imm[15] ? 32'(imm) - 32'd65536 : 32'(imm);
    ref_jt = ((pc + 32'd4) & 32'hF000_0000) | (32'(ins[25:0]) * 32'd4);
    check_eq("op", 64'(op), 64'(ins >> 26));
    check_eq("rs", 64'(rs), 64'((ins >> 21) & 32'h1F));
    check_eq("rt", 64'(rt), 64'((ins >> 16) & 32'h1F));
    check_eq("rd", 64'(rd), 64'((ins >> 11) & 32'h1F));
    check_eq("sham", 64'(sham), 64'((ins >> 6) & 32'h1F));
    check_eq("funct", 64'(funct), 64'(ins & 32'h3F));
    check_eq("imm16", 64'(imm16), 64'(ins & 32'hFFFF));
    check_eq("imm26", 64'(imm26), 64'(ins & 32'h03FF_FFFF));
    check_eq("format", 64'(format), 64'(ref_fmt));
    check_eq("imm_ext", 64'(imm_ext), 64'(ref_ext));
    check_eq("jump_target", 64'(jump_target), 64'(ref_jt));
    check_eq("pc_out", 64'(pc_out), 64'(pc));
  endtask

  // ---------------- driver ----------------
  // One clock cycle: drive inputs after the falling edge, check against the
  // model, then record the handshakes that the next rising edge will perform.
  task automatic step(input logic iv, input logic [31:0] ins, input logic [31:0] pc,
                      input logic ordy, input logic fl);
    logic acc, oevt;
    @(negedge clk);
    in_valid = iv; instruction = ins; pc_in = pc; out_ready = ordy; flush = fl;
    #1;
    check_eq("out_valid", 64'(out_valid), 64'(exp_q.size() != 0));
    check_eq("in_ready", 64'(in_ready), 64'(exp_q.size() < 2));
    if (out_valid && exp_q.size() != 0) check_bundle(exp_q[0]);
    acc  = iv && in_ready;
    oevt = out_valid && ordy;
    if (oevt && exp_q.size() != 0) void'(exp_q.pop_front());
    if (fl) exp_q.delete();
    else if (acc) exp_q.push_back({ins, pc});
  endtask

  task automatic idle_hold();
    step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
  endtask

  task automatic drain();
    for (int i = 0; i < 4; i++) step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    #2;
    check_eq("rst_out_valid", 64'(out_valid), 64'd0);
    check_eq("rst_op", 64'(op), 64'd0);
    check_eq("rst_imm_ext", 64'(imm_ext), 64'd0);
    check_eq("rst_pc_out", 64'(pc_out), 64'd0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;

    // Single ADDI with a negative immediate.
    step(1'b1, 32'h2108FFFF, 32'h0040_0000, 1'b0, 1'b0);
    idle_hold();
    check_eq("addi_op", 64'(op), 64'h08);
    check_eq("addi_rs", 64'(rs), 64'd8);
    check_eq("addi_rt", 64'(rt), 64'd8);
    check_eq("addi_fmt", 64'(format), 64'd1);
    check_eq("addi_ext", 64'(imm_ext), 64'hFFFF_FFFF);
    check_eq("addi_pc", 64'(pc_out), 64'h0040_0000);
    drain();

    // ORI: the immediate is zero-extended.
    step(1'b1, 32'h3508FFFF, 32'h0040_0004, 1'b0, 1'b0);
    idle_hold();
    check_eq("ori_ext", 64'(imm_ext), 64'h0000_FFFF);
    drain();
    // LUI: the immediate goes into the upper half.
    step(1'b1, 32'h3C081234, 32'h0040_0008, 1'b0, 1'b0);
    idle_hold();
    check_eq("lui_ext", 64'(imm_ext), 64'h1234_0000);
    drain();
    // R-type ADD.
    step(1'b1, 32'h01095020, 32'h0040_000C, 1'b0, 1'b0);
    idle_hold();
    check_eq("add_fmt", 64'(format), 64'd0);
    check_eq("add_rd", 64'(rd), 64'd10);
    check_eq("add_funct", 64'(funct), 64'h20);
    drain();
    // J near a 256 MiB boundary: pc+4 carries into the upper nibble.
    step(1'b1, 32'h08100004, 32'h0FFF_FFFC, 1'b0, 1'b0);
    idle_hold();
    check_eq("j_fmt", 64'(format), 64'd2);
    check_eq("j_imm26", 64'(imm26), 64'h0100004);
    check_eq("j_target", 64'(jump_target), 64'h1040_0010);
    drain();

    // Backpressure: 4 words, with out_ready low from the second cycle.
    step(1'b1, 32'h2001_0001, 32'h100, 1'b1, 1'b0);
    step(1'b1, 32'h2002_0002, 32'h104, 1'b0, 1'b0);
    step(1'b1, 32'h2003_0003, 32'h108, 1'b0, 1'b0);
    check_eq("bp_in_ready_low", 64'(in_ready), 64'd0);
    step(1'b1, 32'h2003_0003, 32'h108, 1'b0, 1'b0);
    step(1'b1, 32'h2003_0003, 32'h108, 1'b1, 1'b0);
    step(1'b1, 32'h2003_0003, 32'h108, 1'b1, 1'b0);
    step(1'b1, 32'h2004_0004, 32'h10C, 1'b1, 1'b0);
    drain();
    check_eq("bp_drained", 64'(exp_q.size()), 64'd0);

    // Flush with both entries full and a new input present.
    step(1'b1, 32'h2005_0005, 32'h200, 1'b0, 1'b0);
    step(1'b1, 32'h2006_0006, 32'h204, 1'b0, 1'b0);
    step(1'b1, 32'h2007_0007, 32'h208, 1'b0, 1'b1);
    idle_hold();
    check_eq("flush_out_valid", 64'(out_valid), 64'd0);
    check_eq("flush_in_ready", 64'(in_ready), 64'd1);
    drain();

    // Asynchronous reset pulse between edges while the skid is full.
    step(1'b1, 32'h2008_0008, 32'h300, 1'b0, 1'b0);
    step(1'b1, 32'h2009_0009, 32'h304, 1'b0, 1'b0);
    in_valid = 1'b0;
    #1 rst = 1'b1;
    #1;
    check_eq("arst_out_valid", 64'(out_valid), 64'd0);
    check_eq("arst_op", 64'(op), 64'd0);
    check_eq("arst_imm_ext", 64'(imm_ext), 64'd0);
    check_eq("arst_pc_out", 64'(pc_out), 64'd0);
    #1 rst = 1'b0;
    exp_q.delete();
    check_eq("arst_in_ready", 64'(in_ready), 64'd1);

    // Randomized traffic. Opcodes favour the special cases.
    for (int n = 0; n < 3000; n++) begin
      logic [31:0] ins, pc;
      ins = $urandom;
      case ($urandom_range(0, 7))
        0: ins[31:26] = 6'h00;
        1: ins[31:26] = 6'(32'h02 + $urandom_range(0, 1));
        2: ins[31:26] = 6'(32'h0C + $urandom_range(0, 3));
        default: ;
      endcase
      pc = $urandom;
      pc[1:0] = 2'b00;
      step(1'($urandom_range(0, 3) != 0), ins, pc,
           1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 40) == 0));
    end
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/decode_pipe.md
Name: decode_pipe

Overview:
- Registered, flow-controlled MIPS instruction decode stage.
- Splits each instruction into op/rs/rt/rd/sham/funct/imm16/imm26, classifies its format, produces an extended immediate and a jump target, and forwards the PC.
- Sits between fetch and register-read with a valid/ready handshake on both sides.
- A two-entry skid buffer provides full throughput under backpressure; synchronous flush supports branch redirect.

Parameters:
- DATA_WIDTH, 32, width of imm_ext; must be >= 32.
- ADDR_WIDTH, 32, width of pc_in/pc_out/jump_target; must be >= 28.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- flush  input  1  synchronous; discards all held and incoming instructions.
- in_valid  input  1  upstream instruction/pc valid.
- in_ready  output  1  stage can accept this cycle.
- instruction  input  32  instruction word.
- pc_in  input  ADDR_WIDTH  address of instruction.
- out_valid  output  1  decoded bundle valid.
- out_ready  input  1  downstream accepts.
- op  output  6  instruction[31:26].
- rs  output  5  instruction[25:21].
- rt  output  5  instruction[20:16].
- rd  output  5  instruction[15:11].
- sham  output  5  instruction[10:6].
- funct  output  6  instruction[5:0].
- imm16  output  16  instruction[15:0].
- imm26  output  26  instruction[25:0].
- format  output  2  00 R-type, 01 I-type, 10 J-type.
- imm_ext  output  DATA_WIDTH  extended immediate.
- jump_target  output  ADDR_WIDTH  J-type target.
- pc_out  output  ADDR_WIDTH  pc of the presented instruction.

Behaviour:
- Storage: main register (drives all outputs) and skid register, each with its own valid bit. Decode logic is combinational on the input word; decoded values are captured into whichever register receives the word.
- Reset (async, rst=1): both valid bits 0; all data outputs 0; out_valid=0; in_ready=1 once rst deasserts.
- in_ready = !skid_valid (registered state only; no combinational path from out_ready).
- Accept event: in_valid && in_ready. Output event: out_valid && out_ready.
- Latency: an accepted word appears on outputs the next cycle when main is empty or draining.
- Per clock, with flush=0:
  - Main empty, or output event this cycle: main <= skid if skid_valid, else accepted input; skid_valid <= 0 when skid moved to main. If skid moved to main and an input is also accepted, that input goes to skid. This case cannot occur, since in_ready=0 while skid_valid=1.
  - Main full and no output event: an accepted input goes to skid (skid_valid <= 1); main unchanged.
  - No accept and no output event: hold everything.
- Ordering: strict FIFO; skid contents always precede any newer input.
- Outputs are stable while out_valid && !out_ready.
- flush=1 (overrides all else): both valid bits <= 0; any input accepted that cycle is dropped; output event still counts as consumed downstream; data registers may hold stale values.
- Format: op==0 -> 00; op==2 (J) or op==3 (JAL) -> 10; otherwise 01.
- imm_ext:
  - op in {0x0C ANDI, 0x0D ORI, 0x0E XORI}: zero-extend imm16.
  - op==0x0F (LUI): {imm16, 16'b0}, zero-extended to DATA_WIDTH.
  - All other ops, including R-type: sign-extend imm16 to DATA_WIDTH.
- jump_target = {pc_plus4[ADDR_WIDTH-1:28], imm26, 2'b00}, where pc_plus4 = pc_in + 4 (ADDR_WIDTH, wraps modulo 2^ADDR_WIDTH). Computed for every format.
- Reset mid-transfer: both entries discarded asynchronously; no partial bundle ever presented.

Test Plan:
- Reset then single word: in instruction=0x2108FFFF (ADDI rt=8, rs=8), pc_in=0x00400000 -> next cycle out_valid=1, op=0x08, rs=8, rt=8, format=01, imm_ext=0xFFFFFFFF, pc_out=0x00400000.
- Extension modes: ORI 0x3508FFFF -> imm_ext=0x0000FFFF; LUI 0x3C081234 -> imm_ext=0x12340000; R-type ADD 0x01095020 -> format=00, rd=10, funct=0x20.
- Jump: J 0x08100004 at pc_in=0x0FFFFFFC -> format=10, imm26=0x0100004, jump_target=0x10400010 (pc+4 upper nibble=1).
- Backpressure: stream 4 words with in_valid=1; hold out_ready=0 from cycle 2 -> in_ready falls after 2 words held; release out_ready -> all 4 emerge in order, none lost or duplicated, 1 word/cycle once flowing.
- Flush: with main and skid both full, assert flush with in_valid=1 -> next cycle out_valid=0, in_ready=1; flushed-cycle input never appears.
- Async reset mid-stall: rst pulse between clock edges with skid full -> out_valid drops immediately, outputs 0, in_ready=1 after release.
